multi_push_fifo: RTL and testbench

Circular-buffer FIFO that accepts up to NUM_PUSH writes and one pop per cycle. Same-cycle writes are packed into consecutive slots in ascending port order. It is the successor to the single-push FIFO and feeds arbiters and event queues where several producers can enqueue in one cycle. The pop side is show-ahead with registered outputs. Occupancy and sticky overflow status are exported for the arbiter and for debug.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/push_compactor.sv | 41 ++++
 rtl/multi_push_fifo.sv | 108 ++++++++++
 tb/tb_multi_push_fifo.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: pointer/count width sizing and population count.
package fifo_pkg;

    // Bits needed to index `depth` distinct values; never less than one.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/push_compactor.sv
// Ranks same-cycle push requests by ascending port index and decides which fit in the free space.
module push_compactor
    import fifo_pkg::*;
#(
    parameter int NUM_PUSH   = 2,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic [NUM_PUSH-1:0]                 push_valid,
    input  logic [DEPTH_LOG2+1:0]               free,
    output logic [NUM_PUSH-1:0][DEPTH_LOG2-1:0] offset,
    output logic [NUM_PUSH-1:0]                 accept,
    output logic [DEPTH_LOG2:0]                 n_acc,
    output logic                                drop
);
    localparam int PW = DEPTH_LOG2;
    localparam int XW = DEPTH_LOG2 + 2;

    logic [XW-1:0] w_n_req;
    logic [XW-1:0] w_rank;

    assign w_n_req = XW'(popcount(32'(push_valid)));

    // NOTE: blocking assignments here build a running prefix sum; each port sees the rank left by lower ports.
    always_comb begin
        w_rank = '0;
        offset = '0;
        accept = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            offset[i] = w_rank[PW-1:0];
            accept[i] = push_valid[i] && (w_rank < free);
            if (push_valid[i]) begin
                w_rank = w_rank + XW'(1);
            end
        end
    end

    // free never exceeds DEPTH, so the narrower n_acc holds the minimum exactly.
    assign n_acc = (w_n_req < free) ? w_n_req[DEPTH_LOG2:0] : free[DEPTH_LOG2:0];
    assign drop  = (w_n_req > free);

endmodule

// File: rtl/multi_push_fifo.sv
// Circular-buffer FIFO with NUM_PUSH packed write ports and a registered show-ahead pop side.
module multi_push_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_PUSH   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PUSH-1:0]       push_valid,
    input  logic [NUM_PUSH*WIDTH-1:0] push_data,
    output logic                      push_ready,
    input  logic                      pop_ready,
    output logic                      pop_valid,
    output logic [WIDTH-1:0]          pop_data,
    output logic [DEPTH_LOG2:0]       count,
    output logic                      overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = ptr_width(DEPTH);
    localparam int CW    = ptr_width(DEPTH + 1);
    localparam int XW    = CW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_front;
    logic [PW-1:0]    r_back;
    logic [CW-1:0]    r_count;
    logic             r_push_ready;
    logic             r_pop_valid;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_overflow;

    logic                         w_pop_fire;
    logic [XW-1:0]                w_free;
    logic [NUM_PUSH-1:0][PW-1:0]  w_offset;
    logic [NUM_PUSH-1:0]          w_accept;
    logic [CW-1:0]                w_n_acc;
    logic                         w_drop;
    logic [XW-1:0]                w_count_next;
    logic [PW-1:0]                w_front_next;
    logic [WIDTH-1:0]             w_head_data;

    assign w_pop_fire   = pop_ready & r_pop_valid;
    assign w_free       = XW'(DEPTH) - XW'(r_count) + XW'(w_pop_fire);
    assign w_count_next = XW'(r_count) + XW'(w_n_acc) - XW'(w_pop_fire);
    assign w_front_next = r_front + PW'(w_pop_fire);

    push_compactor #(
        .NUM_PUSH   (NUM_PUSH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_compactor (
        .push_valid (push_valid),
        .free       (w_free),
        .offset     (w_offset),
        .accept     (w_accept),
        .n_acc      (w_n_acc),
        .drop       (w_drop)
    );

    // The new head may be a slot being written this edge; the array has not seen it yet.
    always_comb begin
        w_head_data = r_mem[w_front_next];
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (w_accept[i] && ((r_back + w_offset[i]) == w_front_next)) begin
                w_head_data = push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PUSH; i++) begin
            if (w_accept[i]) begin
                r_mem[r_back + w_offset[i]] <= push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front      <= '0;
            r_back       <= '0;
            r_count      <= '0;
            r_push_ready <= 1'b1;
            r_pop_valid  <= 1'b0;
            r_pop_data   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_front      <= w_front_next;
            r_back       <= r_back + PW'(w_n_acc);
            r_count      <= w_count_next[CW-1:0];
            r_push_ready <= (w_count_next <= XW'(DEPTH - NUM_PUSH));
            r_pop_valid  <= (w_count_next != '0);
            r_pop_data   <= w_head_data;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign push_ready = r_push_ready;
    assign pop_valid  = r_pop_valid;
    assign pop_data   = r_pop_data;
    assign count      = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_multi_push_fifo.sv
// Directed bench: a 4-deep dual-push FIFO driven from a vector table, plus a 3-port instance for sparse pushes.
module tb_multi_push_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, NUM_PUSH=2
    logic [1:0]  a_pv;
    logic [15:0] a_pd;
    logic        a_pr;
    logic        a_push_ready, a_pop_valid, a_overflow;
    logic [7:0]  a_pop_data;
    logic [2:0]  a_count;

    // Instance B: DEPTH=4, NUM_PUSH=3
    logic [2:0]  b_pv;
    logic [23:0] b_pd;
    logic        b_pr;
    logic        b_push_ready, b_pop_valid, b_overflow;
    logic [7:0]  b_pop_data;
    logic [2:0]  b_count;

    multi_push_fifo #(.WIDTH(8), .DEPTH_LOG2(2), .NUM_PUSH(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .push_valid(a_pv), .push_data(a_pd), .push_ready(a_push_ready),
        .pop_ready(a_pr), .pop_valid(a_pop_valid), .pop_data(a_pop_data), .count(a_count),
        .overflow(a_overflow)
    );

    multi_push_fifo #(.WIDTH(8), .DEPTH_LOG2(2), .NUM_PUSH(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .push_valid(b_pv), .push_data(b_pd), .push_ready(b_push_ready),
        .pop_ready(b_pr), .pop_valid(b_pop_valid), .pop_data(b_pop_data), .count(b_count),
        .overflow(b_overflow)
    );

    typedef struct {
        logic [1:0]  pv;
        logic [15:0] pd;
        logic        pr;
        logic        e_valid;
        logic        chk_data;
        logic [7:0]  e_data;
        logic [2:0]  e_count;
        logic        e_ready;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic ev, input logic cd, input logic [7:0] ed,
                           input logic [2:0] ec, input logic er, input logic eo);
        check({tag, ".pop_valid"},  32'(a_pop_valid),  32'(ev));
        check({tag, ".count"},      32'(a_count),      32'(ec));
        check({tag, ".push_ready"}, 32'(a_push_ready), 32'(er));
        check({tag, ".overflow"},   32'(a_overflow),   32'(eo));
        if (cd) check({tag, ".pop_data"}, 32'(a_pop_data), 32'(ed));
    endtask

    function automatic vec_t mk(input logic [1:0] pv, input logic [15:0] pd, input logic pr,
                                input logic ev, input logic cd, input logic [7:0] ed,
                                input logic [2:0] ec, input logic er);
        vec_t v;
        v.pv = pv; v.pd = pd; v.pr = pr;
        v.e_valid = ev; v.chk_data = cd; v.e_data = ed; v.e_count = ec; v.e_ready = er;
        return v;
    endfunction

    initial begin
        // idle with pop_ready high
        for (int i = 0; i < 5; i++) vecs[i] = mk(2'b00, 16'h0000, 1'b1, 0, 0, 8'h00, 3'd0, 1);
        // dual push, port 0 ordered first
        vecs[5]  = mk(2'b11, 16'h0B0A, 1'b0, 1, 1, 8'h0A, 3'd2, 1);
        vecs[6]  = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h0B, 3'd1, 1);
        vecs[7]  = mk(2'b00, 16'h0000, 1'b1, 0, 0, 8'h00, 3'd0, 1);
        // fill and wrap: pairs 0..5, one pop per cycle
        vecs[8]  = mk(2'b11, 16'h0100, 1'b0, 1, 1, 8'h00, 3'd2, 1);
        vecs[9]  = mk(2'b11, 16'h0302, 1'b1, 1, 1, 8'h01, 3'd3, 0);
        vecs[10] = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h02, 3'd2, 1);
        vecs[11] = mk(2'b11, 16'h0504, 1'b1, 1, 1, 8'h03, 3'd3, 0);
        vecs[12] = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h04, 3'd2, 1);
        vecs[13] = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h05, 3'd1, 1);
        vecs[14] = mk(2'b00, 16'h0000, 1'b1, 0, 0, 8'h00, 3'd0, 1);
        // full, then pop + single push at count=4
        vecs[15] = mk(2'b11, 16'h2120, 1'b0, 1, 1, 8'h20, 3'd2, 1);
        vecs[16] = mk(2'b11, 16'h2322, 1'b0, 1, 1, 8'h20, 3'd4, 0);
        vecs[17] = mk(2'b01, 16'h0007, 1'b1, 1, 1, 8'h21, 3'd4, 0);
        vecs[18] = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h22, 3'd3, 0);
        vecs[19] = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h23, 3'd2, 1);
        vecs[20] = mk(2'b00, 16'h0000, 1'b1, 1, 1, 8'h07, 3'd1, 1);
        vecs[21] = mk(2'b00, 16'h0000, 1'b1, 0, 0, 8'h00, 3'd0, 1);
        // push + pop at count=1: new entry becomes head
        vecs[22] = mk(2'b01, 16'h0030, 1'b0, 1, 1, 8'h30, 3'd1, 1);
        vecs[23] = mk(2'b01, 16'h0031, 1'b1, 1, 1, 8'h31, 3'd1, 1);
        vecs[24] = mk(2'b00, 16'h0000, 1'b1, 0, 0, 8'h00, 3'd0, 1);

        a_pv = '0; a_pd = '0; a_pr = 1'b0;
        b_pv = '0; b_pd = '0; b_pr = 1'b0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        check_a("reset", 0, 0, 8'h00, 3'd0, 1, 0);

        // sparse ports on the 3-port instance
        b_pv = 3'b101; b_pd = {8'h33, 8'h00, 8'h11};
        tick();
        b_pv = '0; b_pd = '0;
        check("sparse.count", 32'(b_count), 32'd2);
        check("sparse.head0", 32'(b_pop_data), 32'h11);
        check("sparse.ready", 32'(b_push_ready), 32'd0);
        b_pr = 1'b1;
        tick();
        check("sparse.head1", 32'(b_pop_data), 32'h33);
        check("sparse.count1", 32'(b_count), 32'd1);
        tick();
        b_pr = 1'b0;
        check("sparse.empty", 32'(b_pop_valid), 32'd0);
        check("sparse.overflow", 32'(b_overflow), 32'd0);

        for (int i = 0; i < NV; i++) begin
            a_pv = vecs[i].pv; a_pd = vecs[i].pd; a_pr = vecs[i].pr;
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].chk_data, vecs[i].e_data,
                    vecs[i].e_count, vecs[i].e_ready, 1'b0);
        end

        // overflow at count=3: 0xE stored, 0xF dropped
        a_pr = 1'b0;
        a_pv = 2'b11; a_pd = 16'h0201; tick();
        a_pv = 2'b01; a_pd = 16'h0003; tick();
        check_a("ovf.pre", 1, 1, 8'h01, 3'd3, 0, 0);
        a_pv = 2'b11; a_pd = 16'h0F0E; tick();
        a_pv = 2'b00; a_pd = '0;
        check_a("ovf.hit", 1, 1, 8'h01, 3'd4, 0, 1);
        a_pr = 1'b1;
        tick(); check_a("ovf.d1", 1, 1, 8'h02, 3'd3, 0, 1);
        tick(); check_a("ovf.d2", 1, 1, 8'h03, 3'd2, 1, 1);
        tick(); check_a("ovf.d3", 1, 1, 8'h0E, 3'd1, 1, 1);
        tick(); check_a("ovf.d4", 0, 0, 8'h00, 3'd0, 1, 1);

        // mid-stream reset with count=3, observed without a clock edge
        a_pr = 1'b0;
        a_pv = 2'b11; a_pd = 16'h4241; tick();
        a_pv = 2'b01; a_pd = 16'h0043; tick();
        a_pv = 2'b00; a_pd = '0;
        check("rst.pre_count", 32'(a_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("rst.async", 0, 0, 8'h00, 3'd0, 1, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check_a("rst.after", 0, 0, 8'h00, 3'd0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
